// File: rtl/sensor_link_seq.sv
// sensor_link_seq: measure -> settle -> stream sensor bytes -> collect reply bytes.
// Receive-timeout path (timer, ERRO state, erro flag) is built only with SEQ_RX_TIMEOUT_EN.
module sensor_link_seq #(
  parameter int N_SENSORS        = 3,
  parameter int BYTES_PER_SENSOR = 4,
  parameter int N_RX             = 3,
  parameter int WAIT_CYCLES      = 50000000,
  parameter int RX_TIMEOUT       = 100000000,
  localparam int SW = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1,
  localparam int BW = (BYTES_PER_SENSOR > 1) ? $clog2(BYTES_PER_SENSOR) : 1,
  localparam int RW = (N_RX > 1) ? $clog2(N_RX) : 1,
  localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1,
  localparam int TW = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          jogar,
  input  logic          modo_continuo,
  input  logic          pronto_serial,
  input  logic          pronto_recepcao,
  output logic          medir,
  output logic          partida_tx,
  output logic [SW-1:0] sensor_idx,
  output logic [BW-1:0] byte_idx,
  output logic [RW-1:0] rx_idx,
  output logic          pronto,
  output logic          erro,
  output logic [3:0]    db_estado
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_MEDIR      = 4'd1,
    S_ESPERA     = 4'd2,
    S_ENVIA      = 4'd3,
    S_AGUARDA_TX = 4'd4,
    S_PROX_BYTE  = 4'd5,
    S_ESPERA_RX  = 4'd6,
    S_PROX_RX    = 4'd7,
    S_FINAL      = 4'd8,
    S_ERRO       = 4'd9
  } state_t;

  state_t        state_q;
  logic [SW-1:0] sensor_q;
  logic [BW-1:0] byte_q;
  logic [RW-1:0] rx_q;
  logic [WW-1:0] wait_q;
  logic          medir_q;
  logic          partida_q;
  logic          pronto_q;
`ifdef SEQ_RX_TIMEOUT_EN
  logic [TW-1:0] tmo_q;
  logic          erro_q;
`endif

  // Pulse outputs are registered: each appears the cycle after the state that produces it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sensor_q  <= '0;
      byte_q    <= '0;
      rx_q      <= '0;
      wait_q    <= '0;
      medir_q   <= 1'b0;
      partida_q <= 1'b0;
      pronto_q  <= 1'b0;
`ifdef SEQ_RX_TIMEOUT_EN
      tmo_q     <= '0;
      erro_q    <= 1'b0;
`endif
    end else begin
      medir_q   <= 1'b0;
      partida_q <= 1'b0;
      pronto_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          sensor_q <= '0;
          byte_q   <= '0;
          rx_q     <= '0;
          wait_q   <= '0;
`ifdef SEQ_RX_TIMEOUT_EN
          tmo_q    <= '0;
`endif
          if (jogar) begin
            state_q <= S_MEDIR;
`ifdef SEQ_RX_TIMEOUT_EN
            erro_q  <= 1'b0;
`endif
          end
        end
        S_MEDIR: begin
          medir_q <= 1'b1;
          state_q <= S_ESPERA;
        end
        S_ESPERA: begin
          if (wait_q == WW'(WAIT_CYCLES - 1)) begin
            wait_q  <= '0;
            state_q <= S_ENVIA;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_ENVIA: begin
          partida_q <= 1'b1;
          state_q   <= S_AGUARDA_TX;
        end
        S_AGUARDA_TX: begin
          if (pronto_serial) state_q <= S_PROX_BYTE;
        end
        S_PROX_BYTE: begin
          if (byte_q == BW'(BYTES_PER_SENSOR - 1)) begin
            if (sensor_q == SW'(N_SENSORS - 1)) begin
              state_q <= S_ESPERA_RX;
            end else begin
              byte_q   <= '0;
              sensor_q <= sensor_q + 1'b1;
              state_q  <= S_ENVIA;
            end
          end else begin
            byte_q  <= byte_q + 1'b1;
            state_q <= S_ENVIA;
          end
        end
        S_ESPERA_RX: begin
          // A reply byte arriving on the expiry cycle still counts.
          if (pronto_recepcao) begin
            state_q <= S_PROX_RX;
`ifdef SEQ_RX_TIMEOUT_EN
          end else if (tmo_q == TW'(RX_TIMEOUT - 1)) begin
            state_q <= S_ERRO;
          end else begin
            tmo_q <= tmo_q + 1'b1;
`endif
          end
        end
        S_PROX_RX: begin
`ifdef SEQ_RX_TIMEOUT_EN
          tmo_q <= '0;
`endif
          if (rx_q == RW'(N_RX - 1)) begin
            state_q <= S_FINAL;
          end else begin
            rx_q    <= rx_q + 1'b1;
            state_q <= S_ESPERA_RX;
          end
        end
        S_FINAL: begin
          pronto_q <= 1'b1;
          sensor_q <= '0;
          byte_q   <= '0;
          rx_q     <= '0;
          state_q  <= modo_continuo ? S_MEDIR : S_IDLE;
        end
`ifdef SEQ_RX_TIMEOUT_EN
        S_ERRO: begin
          erro_q   <= 1'b1;
          sensor_q <= '0;
          byte_q   <= '0;
          rx_q     <= '0;
          state_q  <= S_IDLE;
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign medir      = medir_q;
  assign partida_tx = partida_q;
  assign pronto     = pronto_q;
  assign sensor_idx = sensor_q;
  assign byte_idx   = byte_q;
  assign rx_idx     = rx_q;
  assign db_estado  = state_q;

`ifdef SEQ_RX_TIMEOUT_EN
  assign erro = erro_q;
`else
  logic [31:0] unused_rx_timeout;
  assign unused_rx_timeout = RX_TIMEOUT;
  assign erro = 1'b0;
`endif

endmodule

// File: tb/tb_sensor_link_seq.sv
// Self-checking bench for sensor_link_seq; expectations follow the settle/transmit/receive timing rules.
module tb_sensor_link_seq;
  localparam int NS = 3, BPS = 4, NRX = 3, WC = 4, RT = 20;
  localparam int TOTAL = NS * BPS;

  logic clock = 1'b0;
  logic reset, jogar, modo_continuo, pronto_serial, pronto_recepcao;
  logic medir, partida_tx, pronto, erro;
  logic [1:0] sensor_idx, byte_idx, rx_idx;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clock = ~clock;

  sensor_link_seq #(
    .N_SENSORS(NS), .BYTES_PER_SENSOR(BPS), .N_RX(NRX),
    .WAIT_CYCLES(WC), .RX_TIMEOUT(RT)
  ) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .modo_continuo(modo_continuo),
    .pronto_serial(pronto_serial), .pronto_recepcao(pronto_recepcao),
    .medir(medir), .partida_tx(partida_tx), .sensor_idx(sensor_idx),
    .byte_idx(byte_idx), .rx_idx(rx_idx), .pronto(pronto), .erro(erro),
    .db_estado(db_estado)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Outputs are sampled 1 time unit after each rising edge; cyc counts edges.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic start(output int k);
    jogar = 1'b1;
    step();
    jogar = 1'b0;
    k = cyc;
  endtask

  // Drives one sequence whose MEDIR state was entered at edge k and checks it against the timing rules.
  // lat=0 -> random transmitter latency; rx_send=0 -> stop as soon as ESPERA_RX is reached.
  task automatic run_seq(input int k, input int lat, input int rx_send, input bit stray, output int end_cyc);
    int exp_tx, n, tx_cd, rx_left, rx_gap, last_rx, l;
    bit done, medir_seen;
    exp_tx = k + 2 + WC; n = 0; tx_cd = 0; rx_left = rx_send;
    rx_gap = $urandom_range(0, 4); last_rx = -100; done = 0; medir_seen = 0; end_cyc = -1;
    while (!done && cyc < k + 800) begin
      step();
      pronto_serial = 1'b0;
      pronto_recepcao = 1'b0;
      if (medir) begin
        checks++; medir_seen = 1;
        if (cyc != k + 1) begin
          errors++; $display("FAIL medir_timing: medir at start+%0d, required start+1", cyc - k);
        end
      end
      if (tx_cd > 0) tx_cd--;
      if (partida_tx) begin
        checks++;
        if (n >= TOTAL || cyc != exp_tx || sensor_idx !== 2'(n / BPS) || byte_idx !== 2'(n % BPS)) begin
          errors++;
          $display("FAIL partida_tx #%0d: cycle %0d sensor %0d byte %0d, required cycle %0d sensor %0d byte %0d",
                   n, cyc, sensor_idx, byte_idx, exp_tx, n / BPS, n % BPS);
        end
        n++;
        l = (lat > 0) ? lat : int'($urandom_range(1, 6));
        tx_cd = l;
      end
      if (tx_cd == 1) begin
        pronto_serial = 1'b1;
        exp_tx = cyc + 3;
      end
      if (stray && cyc >= k + 1 && cyc <= k + WC) begin
        pronto_serial = 1'b1;
        pronto_recepcao = 1'b1;
      end
      if (rx_left > 0 && db_estado == 4'd6) begin
        if (rx_gap == 0) begin
          checks++;
          if (rx_idx !== 2'(rx_send - rx_left)) begin
            errors++; $display("FAIL rx_idx: got %0d, required %0d", rx_idx, rx_send - rx_left);
          end
          pronto_recepcao = 1'b1;
          last_rx = cyc + 1;
          rx_left--;
          rx_gap = $urandom_range(0, 4);
        end else begin
          rx_gap--;
        end
      end
      if (rx_send == 0 && db_estado == 4'd6) begin
        done = 1; end_cyc = cyc;
      end
      if (pronto) begin
        checks++;
        if (cyc != last_rx + 2 || rx_left != 0 || n != TOTAL) begin
          errors++;
          $display("FAIL pronto_timing: cycle %0d (rx left %0d, tx %0d), required cycle %0d", cyc, rx_left, n, last_rx + 2);
        end
        done = 1; end_cyc = cyc;
      end
    end
    pronto_serial = 1'b0;
    pronto_recepcao = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL run_timeout: sequence did not complete, state %0d", db_estado); end
    checks++;
    if (!medir_seen) begin errors++; $display("FAIL medir_missing: no medir pulse, required 1"); end
    checks++;
    if (n != TOTAL) begin errors++; $display("FAIL tx_count: got %0d partida_tx, required %0d", n, TOTAL); end
  endtask

  task automatic expect_idle(input string name, input int ncyc);
    int bad;
    bad = 0;
    repeat (ncyc) begin
      step();
      if (db_estado !== 4'd0 || medir !== 1'b0 || pronto !== 1'b0 || partida_tx !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL %s: %0d non-idle cycles, required 0", name, bad); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if ({medir, partida_tx, pronto, erro, sensor_idx, byte_idx, rx_idx, db_estado} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required all zero",
               {medir, partida_tx, pronto, erro, sensor_idx, byte_idx, rx_idx, db_estado});
    end
    reset = 1'b0;
    expect_idle("idle_hold", 50);
  endtask

  task automatic test_full_run();
    int k, e;
    start(k);
    run_seq(k, 5, NRX, 1'b0, e);
    expect_idle("after_full_run", 5);
  endtask

  task automatic test_random_runs();
    int k, e;
    for (int r = 0; r < 3; r++) begin
      start(k);
      run_seq(k, 0, NRX, 1'b0, e);
      expect_idle("after_random_run", 3);
    end
  endtask

  task automatic test_stray();
    int k, e;
    start(k);
    run_seq(k, 0, NRX, 1'b1, e);
    expect_idle("after_stray_run", 3);
  endtask

  task automatic test_timeout();
    int k, e, bad;
    start(k);
    run_seq(k, 0, 0, 1'b0, e);
`ifdef SEQ_RX_TIMEOUT_EN
    bad = 0;
    repeat (RT - 1) begin
      step();
      if (db_estado !== 4'd6 || erro !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL timeout_early: %0d cycles left ESPERA_RX, required 0", bad); end
    step();
    checks++;
    if (db_estado !== 4'd9) begin errors++; $display("FAIL timeout_erro_state: state %0d at entry+%0d, required 9", db_estado, cyc - e); end
    step();
    checks++;
    if (db_estado !== 4'd0 || erro !== 1'b1) begin
      errors++; $display("FAIL timeout_flag: state %0d erro %b, required state 0 erro 1", db_estado, erro);
    end
    repeat (5) step();
    checks++;
    if (erro !== 1'b1) begin errors++; $display("FAIL erro_sticky: erro %b, required 1", erro); end
    start(k);
    checks++;
    if (erro !== 1'b0 || db_estado !== 4'd1) begin
      errors++; $display("FAIL erro_clear: erro %b state %0d, required erro 0 state 1", erro, db_estado);
    end
`else
    bad = 0;
    repeat (RT + 30) begin
      step();
      if (db_estado !== 4'd6 || erro !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL no_timeout_hold: %0d cycles off state 6 or erro set, required 0", bad); end
`endif
    reset = 1'b1;
    step();
    reset = 1'b0;
    expect_idle("after_timeout_reset", 2);
  endtask

  task automatic test_simultaneous();
    int k, e, rx_left, budget;
    bit seen;
    start(k);
    run_seq(k, 0, 0, 1'b0, e);
    repeat (RT - 1) step();
    pronto_recepcao = 1'b1;
    step();
    pronto_recepcao = 1'b0;
    checks++;
    if (db_estado !== 4'd7 || erro !== 1'b0) begin
      errors++; $display("FAIL coincident_rx: state %0d erro %b, required state 7 erro 0", db_estado, erro);
    end
    rx_left = NRX - 1; seen = 0; budget = 0;
    while (!seen && budget < 60) begin
      step();
      budget++;
      pronto_recepcao = 1'b0;
      if (pronto) seen = 1;
      else if (rx_left > 0 && db_estado == 4'd6) begin
        pronto_recepcao = 1'b1; rx_left--;
      end
    end
    pronto_recepcao = 1'b0;
    checks++;
    if (!seen || erro !== 1'b0) begin
      errors++; $display("FAIL coincident_complete: pronto seen %0d erro %b, required 1 and 0", seen, erro);
    end
    expect_idle("after_coincident", 3);
  endtask

  task automatic test_continuous();
    int k, e1, e2;
    modo_continuo = 1'b1;
    start(k);
    run_seq(k, 0, NRX, 1'b0, e1);
    modo_continuo = 1'b0;
    run_seq(e1, 0, NRX, 1'b0, e2);
    checks++;
    if (e2 - e1 < 2 + WC + TOTAL * 3) begin
      errors++; $display("FAIL continuous_second_run: length %0d, required at least %0d", e2 - e1, 2 + WC + TOTAL * 3);
    end
    expect_idle("after_continuous", 4);
  endtask

  task automatic test_abort();
    int k, cnt, budget;
    bit hit;
    start(k);
    cnt = 0; hit = 0; budget = 0;
    while (!hit && budget < 200) begin
      step();
      budget++;
      pronto_serial = 1'b0;
      if (partida_tx) cnt++;
      if (db_estado == 4'd4) begin
        if (cnt >= 3) hit = 1;
        else pronto_serial = 1'b1;
      end
    end
    checks++;
    if (!hit || byte_idx !== 2'd2 || sensor_idx !== 2'd0) begin
      errors++; $display("FAIL abort_setup: reached %0d sensor %0d byte %0d, required 1 0 2", hit, sensor_idx, byte_idx);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (db_estado !== 4'd0 || sensor_idx !== 2'd0 || byte_idx !== 2'd0 || rx_idx !== 2'd0 || pronto !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: state %0d idx %0d/%0d/%0d pronto %b, required all 0",
               db_estado, sensor_idx, byte_idx, rx_idx, pronto);
    end
    expect_idle("after_abort", 10);
  endtask

  initial begin
    reset = 1'b1; jogar = 1'b0; modo_continuo = 1'b0;
    pronto_serial = 1'b0; pronto_recepcao = 1'b0;
    test_reset();
    test_full_run();
    test_random_runs();
    test_stray();
    test_timeout();
    test_simultaneous();
    test_continuous();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
